// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, optional two-entry skid buffer,
// synchronous flush with bubble insertion and a saturating back-pressure counter.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter bit                SKID    = 1'b1,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e            r_state, w_state_d;
  logic [DATA_W-1:0] r_main, w_main_d;
  logic [DATA_W-1:0] r_skid, w_skid_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              r_in_ready, w_in_ready_d;
  logic              w_out_valid, w_in_ready;
  logic              w_in_fire, w_out_fire;

  assign w_out_valid = (r_state != StEmpty);
  // Without the skid entry the stage can only accept when its single slot drains this cycle.
  assign w_in_ready  = SKID ? r_in_ready : (!w_out_valid || out_ready);
  assign w_in_fire   = in_valid && w_in_ready;
  assign w_out_fire  = w_out_valid && out_ready;

  always_comb begin
    w_state_d = r_state;
    w_main_d  = r_main;
    w_skid_d  = r_skid;
    case (r_state)
      StEmpty: begin
        if (w_in_fire) begin
          w_state_d = StOne;
          w_main_d  = in_data;
        end
      end
      StOne: begin
        if (w_in_fire && w_out_fire) begin
          w_main_d = in_data;
        end else if (w_in_fire && SKID) begin
          w_state_d = StTwo;
          w_skid_d  = in_data;
        end else if (w_out_fire) begin
          w_state_d = StEmpty;
        end
      end
      StTwo: begin
        if (w_out_fire) begin
          w_state_d = StOne;
          w_main_d  = r_skid;
        end
      end
      default: w_state_d = StEmpty;
    endcase
    if (flush) begin
      w_state_d = StEmpty;
      w_main_d  = NOP_VAL;
      w_skid_d  = NOP_VAL;
    end
    w_in_ready_d = (w_state_d != StTwo);
  end

  always_comb begin
    w_cnt_d = r_cnt;
    if (cnt_clr) begin
      w_cnt_d = '0;
    end else if (w_out_valid && !out_ready && (r_cnt != {CNT_W{1'b1}})) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StEmpty;
      r_main     <= NOP_VAL;
      r_skid     <= NOP_VAL;
      r_cnt      <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_d;
      r_main     <= w_main_d;
      r_skid     <= w_skid_d;
      r_cnt      <= w_cnt_d;
      r_in_ready <= w_in_ready_d;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? r_main : NOP_VAL;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=4) and a non-skid instance, each checked
// every cycle against a queue model, plus pinned literal expectations.
module tb_pipe_stage_reg;

  localparam logic [7:0] NopA = 8'hEE;
  localparam logic [7:0] NopB = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_in_valid = 0, a_in_ready, a_flush = 0, a_out_valid, a_out_ready = 1, a_cnt_clr = 0;
  logic [7:0] a_in_data = 0, a_out_data;
  logic [3:0] a_stall_cnt;
  logic       b_in_valid = 0, b_in_ready, b_flush = 0, b_out_valid, b_out_ready = 0, b_cnt_clr = 0;
  logic [7:0] b_in_data = 0, b_out_data;
  logic [7:0] b_stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(8), .NOP_VAL(NopA), .SKID(1'b1), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .cnt_clr(a_cnt_clr), .stall_cnt(a_stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(8), .NOP_VAL(NopB), .SKID(1'b0), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .cnt_clr(b_cnt_clr), .stall_cnt(b_stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Literal expectations requested by the stimulus, checked at the next falling edge.
  bit       pa_en = 0, pa_v, pa_r;
  bit       pb_en = 0, pb_v, pb_r;
  logic [7:0] pa_d, pb_d;
  int       pa_c, pb_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int ca = 0, cb = 0;

  initial begin
    bit ova, ira, ovb, irb, fin, fout;
    logic [7:0] oda, odb;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        qa.delete(); qb.delete(); ca = 0; cb = 0;
      end
      ova = (qa.size() != 0);
      ira = (qa.size() < 2);
      oda = ova ? qa[0] : NopA;
      ovb = (qb.size() != 0);
      irb = (qb.size() == 0) || b_out_ready;
      odb = ovb ? qb[0] : NopB;
      check("a_out_valid", 32'(a_out_valid), 32'(ova));
      check("a_out_data", 32'(a_out_data), 32'(oda));
      check("a_in_ready", 32'(a_in_ready), 32'(ira));
      check("a_stall_cnt", 32'(a_stall_cnt), 32'(ca));
      check("b_out_valid", 32'(b_out_valid), 32'(ovb));
      check("b_out_data", 32'(b_out_data), 32'(odb));
      check("b_in_ready", 32'(b_in_ready), 32'(irb));
      check("b_stall_cnt", 32'(b_stall_cnt), 32'(cb));
      if (pa_en) begin
        check("pin_a_valid", 32'(a_out_valid), 32'(pa_v));
        check("pin_a_data", 32'(a_out_data), 32'(pa_d));
        check("pin_a_ready", 32'(a_in_ready), 32'(pa_r));
        check("pin_a_cnt", 32'(a_stall_cnt), 32'(pa_c));
      end
      if (pb_en) begin
        check("pin_b_valid", 32'(b_out_valid), 32'(pb_v));
        check("pin_b_data", 32'(b_out_data), 32'(pb_d));
        check("pin_b_ready", 32'(b_in_ready), 32'(pb_r));
        check("pin_b_cnt", 32'(b_stall_cnt), 32'(pb_c));
      end
      // Inputs are stable from here to the next rising edge, so advance the model now.
      if (rst_n) begin
        fin  = a_in_valid && ira;
        fout = ova && a_out_ready;
        if (a_cnt_clr) ca = 0;
        else if (ova && !a_out_ready && ca < 15) ca++;
        if (a_flush) qa.delete();
        else begin
          if (fout) void'(qa.pop_front());
          if (fin) qa.push_back(a_in_data);
        end
        fin  = b_in_valid && irb;
        fout = ovb && b_out_ready;
        if (b_cnt_clr) cb = 0;
        else if (ovb && !b_out_ready && cb < 255) cb++;
        if (b_flush) qb.delete();
        else begin
          if (fout) void'(qb.pop_front());
          if (fin) qb.push_back(b_in_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    pa_en = 0;
    pb_en = 0;
  endtask

  task automatic pina(input bit v, input logic [7:0] d, input bit r, input int c);
    pa_v = v; pa_d = d; pa_r = r; pa_c = c; pa_en = 1;
  endtask

  task automatic pinb(input bit v, input logic [7:0] d, input bit r, input int c);
    pb_v = v; pb_d = d; pb_r = r; pb_c = c; pb_en = 1;
  endtask

  initial begin
    tick();
    pina(0, NopA, 1, 0);
    pinb(0, NopB, 1, 0);
    tick();
    rst_n = 1;

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1; a_in_data = 8'(i);
      tick();
      pina(1, 8'(i), 1, 0);
    end
    a_in_valid = 0;
    tick(); tick();

    // Back-pressure into the skid entry, then release.
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h0A;
    tick(); pina(1, 8'h0A, 1, 0);
    a_in_data = 8'h0B;
    tick(); pina(1, 8'h0A, 0, 1);
    a_in_data = 8'h0C;
    tick(); pina(1, 8'h0A, 0, 2);
    tick(); pina(1, 8'h0A, 0, 3);
    a_out_ready = 1;
    tick(); pina(1, 8'h0B, 1, 3);
    tick(); pina(1, 8'h0C, 1, 3);
    a_in_valid = 0;
    tick(); pina(0, NopA, 1, 3);

    // Flush while full, with a payload offered in the same cycle.
    a_cnt_clr = 1;
    tick(); pina(0, NopA, 1, 0);
    a_cnt_clr = 0; a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h0A;
    tick();
    a_in_data = 8'h0B;
    tick();
    a_flush = 1; a_in_data = 8'h0C;
    tick(); pina(0, NopA, 1, 2);
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    tick(); pina(0, NopA, 1, 2);
    tick();

    // Asynchronous reset while holding two payloads.
    a_out_ready = 0; a_in_valid = 1; a_in_data = 8'h0A;
    tick();
    a_in_data = 8'h0B;
    tick();
    a_in_valid = 0;
    #1 rst_n = 0;
    pina(0, NopA, 1, 0);
    tick();
    rst_n = 1;
    tick();

    // Counter saturation, clear during a stall, flush together with clear.
    a_in_valid = 1; a_in_data = 8'h33;
    tick();
    a_in_valid = 0;
    repeat (20) tick();
    pina(1, 8'h33, 1, 15);
    a_cnt_clr = 1;
    tick(); pina(1, 8'h33, 1, 0);
    a_cnt_clr = 0;
    tick(); pina(1, 8'h33, 1, 1);
    a_flush = 1; a_cnt_clr = 1;
    tick(); pina(0, NopA, 1, 0);
    a_flush = 0; a_cnt_clr = 0; a_out_ready = 1;
    tick();

    // Non-skid instance: combinational in_ready.
    b_out_ready = 0; b_in_valid = 1; b_in_data = 8'h11;
    tick(); pinb(1, 8'h11, 0, 0);
    b_in_data = 8'h22;
    tick();
    b_out_ready = 1;
    pinb(1, 8'h11, 1, 1);
    tick(); pinb(1, 8'h22, 1, 1);
    for (int i = 0; i < 3; i++) begin
      b_in_data = 8'h40 + 8'(i);
      tick(); pinb(1, 8'h40 + 8'(i), 1, 1);
    end
    b_in_valid = 0;
    tick(); pinb(0, NopB, 1, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
